// File: rtl/ccu_snoop_ctrl.sv
// ccu_snoop_ctrl: core-0 coherence unit; snoops the peer, sources data from peer or memory,
// writes dirty peer data back and returns the word plus the new MESI state.
module ccu_snoop_ctrl #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int SNOOP_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_state,
    output logic              ccu_busy,
    output logic              CCU_ready,
    output logic [DATA_W-1:0] data_out_CCU,
    output logic [1:0]        cache_upd_state_core,
    output logic              bs_req,
    output logic [ADDR_W-1:0] snoop_address,
    output logic [1:0]        snoop_type,
    input  logic              bs_resp,
    input  logic              snoop_hit,
    input  logic              snoop_dirty,
    input  logic [DATA_W-1:0] snoop_data,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);
    typedef enum logic [2:0] {IDLE, SNOOP, WB_MEM, MEM_RD, DONE} state_t;
    localparam logic [1:0] ST_I = 2'b00, ST_S = 2'b01, ST_E = 2'b10, ST_M = 2'b11;
    localparam logic [1:0] BUS_NONE = 2'b00, BUS_RD = 2'b01, BUS_RDX = 2'b10, BUS_UPGR = 2'b11;

    state_t            state_q, state_d;
    logic              busy_q, busy_d, write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        rstate_q, rstate_d, type_q, type_d, nst_q, nst_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ready_d, bs_req_d, mem_rd_d, mem_wr_d;
    logic [ADDR_W-1:0] snoop_address_d, mem_addr_d;
    logic [DATA_W-1:0] data_out_d, mem_wdata_d;
    logic [1:0]        snoop_type_d, upd_d;
    logic              hit, dirty;

    assign hit   = bs_resp & snoop_hit;
    assign dirty = bs_resp & snoop_hit & snoop_dirty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            rstate_q <= ST_I;
            type_q   <= BUS_NONE;
            nst_q    <= ST_I;
            cnt_q    <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            rstate_q <= rstate_d;
            type_q   <= type_d;
            nst_q    <= nst_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
        end
    end

    // IDLE with busy_q set is the decode cycle for the request latched on the previous edge
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        write_d  = write_q;
        addr_d   = addr_q;
        rstate_d = rstate_q;
        type_d   = type_q;
        nst_d    = nst_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        case (state_q)
            IDLE: begin
                if (!busy_q && req_valid) begin
                    busy_d   = 1'b1;
                    write_d  = req_write;
                    addr_d   = req_addr;
                    rstate_d = req_state;
                end else if (busy_q) begin
                    cnt_d  = 8'(SNOOP_TIMEOUT);
                    data_d = '0;
                    if (rstate_q == ST_I) begin
                        state_d = SNOOP;
                        type_d  = write_q ? BUS_RDX : BUS_RD;
                    end else if (write_q && rstate_q == ST_S) begin
                        state_d = SNOOP;
                        type_d  = BUS_UPGR;
                    end else begin
                        state_d = DONE;
                        type_d  = BUS_NONE;
                        nst_d   = write_q ? ST_M : rstate_q;
                    end
                end
            end
            SNOOP: begin
                cnt_d = cnt_q - 8'd1;
                if (bs_resp || cnt_q == 8'd1) begin
                    if (type_q == BUS_UPGR) begin
                        state_d = DONE;
                        nst_d   = ST_M;
                    end else if (hit) begin
                        data_d  = snoop_data;
                        nst_d   = (type_q == BUS_RD) ? ST_S : ST_M;
                        state_d = (type_q == BUS_RD && dirty) ? WB_MEM : DONE;
                    end else begin
                        state_d = MEM_RD;
                        nst_d   = (type_q == BUS_RD) ? ST_E : ST_M;
                    end
                end
            end
            WB_MEM: state_d = mem_ack ? DONE : WB_MEM;
            MEM_RD: begin
                if (mem_ack) begin
                    data_d  = mem_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bs_req_d        = state_d == SNOOP;
        snoop_type_d    = bs_req_d ? type_d : BUS_NONE;
        snoop_address_d = bs_req_d ? addr_d : '0;
        mem_rd_d        = state_d == MEM_RD;
        mem_wr_d        = state_d == WB_MEM;
        mem_addr_d      = (mem_rd_d || mem_wr_d) ? addr_d : '0;
        mem_wdata_d     = mem_wr_d ? data_d : '0;
        ready_d         = state_d == DONE;
        data_out_d      = ready_d ? data_d : '0;
        upd_d           = ready_d ? nst_d : ST_I;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ccu_busy             <= 1'b0;
            CCU_ready            <= 1'b0;
            data_out_CCU         <= '0;
            cache_upd_state_core <= ST_I;
            bs_req               <= 1'b0;
            snoop_address        <= '0;
            snoop_type           <= BUS_NONE;
            mem_rd               <= 1'b0;
            mem_wr               <= 1'b0;
            mem_addr             <= '0;
            mem_wdata            <= '0;
        end else begin
            ccu_busy             <= busy_d;
            CCU_ready            <= ready_d;
            data_out_CCU         <= data_out_d;
            cache_upd_state_core <= upd_d;
            bs_req               <= bs_req_d;
            snoop_address        <= snoop_address_d;
            snoop_type           <= snoop_type_d;
            mem_rd               <= mem_rd_d;
            mem_wr               <= mem_wr_d;
            mem_addr             <= mem_addr_d;
            mem_wdata            <= mem_wdata_d;
        end
    end
endmodule

// File: tb/tb_ccu_snoop_ctrl.sv
// tb_ccu_snoop_ctrl: directed checks of snoop, write-back, memory-read, timeout and reset paths.
module tb_ccu_snoop_ctrl;
    logic        clk = 1'b0;
    logic        rst, req_valid, req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_state;
    logic        ccu_busy, CCU_ready, bs_req, mem_rd, mem_wr;
    logic [31:0] data_out_CCU, snoop_address, mem_addr, mem_wdata;
    logic [1:0]  cache_upd_state_core, snoop_type;
    logic        bs_resp, snoop_hit, snoop_dirty, mem_ack;
    logic [31:0] snoop_data, mem_rdata;
    int          tests = 0;
    int          fails = 0;
    int          n;

    ccu_snoop_ctrl #(.ADDR_W(32), .DATA_W(32), .SNOOP_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_state(req_state), .ccu_busy(ccu_busy),
        .CCU_ready(CCU_ready), .data_out_CCU(data_out_CCU),
        .cache_upd_state_core(cache_upd_state_core), .bs_req(bs_req),
        .snoop_address(snoop_address), .snoop_type(snoop_type), .bs_resp(bs_resp),
        .snoop_hit(snoop_hit), .snoop_dirty(snoop_dirty), .snoop_data(snoop_data),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic w, input logic [31:0] a, input logic [1:0] s);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_state = s;
        tick;
        req_valid = 1'b0;
    endtask

    task automatic snoop_resp(input logic h, input logic d, input logic [31:0] sd);
        bs_resp     = 1'b1;
        snoop_hit   = h;
        snoop_dirty = d;
        snoop_data  = sd;
        tick;
        bs_resp     = 1'b0;
        snoop_hit   = 1'b0;
        snoop_dirty = 1'b0;
    endtask

    task automatic mem_resp(input logic [31:0] rd);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        tick;
        mem_ack   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_state = 2'b00;
        bs_resp = 1'b0; snoop_hit = 1'b0; snoop_dirty = 1'b0; snoop_data = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        tick;
        tick;
        rst = 1'b0;
        chk("rst_busy", ccu_busy, 0);
        chk("rst_ready", CCU_ready, 0);
        chk("rst_bsreq", bs_req, 0);
        chk("rst_mem", {mem_rd, mem_wr}, 0);
        chk("rst_data", data_out_CCU, 0);

        // read miss, peer miss -> memory read, E
        request(1'b0, 32'hAABBCCDD, 2'b00);
        chk("t1_busy", ccu_busy, 1);
        chk("t1_no_bsreq_yet", bs_req, 0);
        tick;
        chk("t1_bsreq", {bs_req, snoop_type}, {1'b1, 2'b01});
        chk("t1_saddr", snoop_address, 32'hAABBCCDD);
        tick;
        tick;
        chk("t1_bsreq_held", {bs_req, snoop_type}, {1'b1, 2'b01});
        snoop_resp(1'b0, 1'b0, 32'h0);
        chk("t1_bsreq_drop", bs_req, 0);
        chk("t1_memrd", {mem_rd, mem_wr}, 2'b10);
        chk("t1_maddr", mem_addr, 32'hAABBCCDD);
        tick;
        chk("t1_memrd_held", mem_rd, 1);
        mem_resp(32'hDEADBEEF);
        chk("t1_ready", CCU_ready, 1);
        chk("t1_data", data_out_CCU, 32'hDEADBEEF);
        chk("t1_state", cache_upd_state_core, 2'b10);
        chk("t1_busy_incl", ccu_busy, 1);
        tick;
        chk("t1_ready_pulse", CCU_ready, 0);
        chk("t1_idle", ccu_busy, 0);

        // read miss, peer dirty -> write-back, S
        request(1'b0, 32'hAABBCCDD, 2'b00);
        tick;
        snoop_resp(1'b1, 1'b1, 32'h12345678);
        chk("t2_memwr", {mem_rd, mem_wr}, 2'b01);
        chk("t2_wdata", mem_wdata, 32'h12345678);
        chk("t2_maddr", mem_addr, 32'hAABBCCDD);
        chk("t2_not_ready", CCU_ready, 0);
        mem_resp(32'h0);
        chk("t2_ready", {CCU_ready, mem_wr}, 2'b10);
        chk("t2_data", data_out_CCU, 32'h12345678);
        chk("t2_state", cache_upd_state_core, 2'b01);
        tick;

        // write on S -> BusUpgr, no memory traffic, M, data 0
        request(1'b1, 32'h00001000, 2'b01);
        tick;
        chk("t3_type", {bs_req, snoop_type}, {1'b1, 2'b11});
        snoop_resp(1'b1, 1'b1, 32'h55555555);
        chk("t3_ready", CCU_ready, 1);
        chk("t3_state", cache_upd_state_core, 2'b11);
        chk("t3_data", data_out_CCU, 0);
        chk("t3_nomem", {mem_rd, mem_wr}, 0);
        tick;

        // write miss, snoop timeout -> memory read, M
        request(1'b1, 32'h00002000, 2'b00);
        tick;
        chk("t4_type", {bs_req, snoop_type}, {1'b1, 2'b10});
        n = 0;
        while (bs_req && n < 40) begin
            n++;
            tick;
        end
        chk("t4_timeout_cycles", n, 16);
        chk("t4_memrd", {mem_rd, mem_wr}, 2'b10);
        snoop_resp(1'b1, 1'b0, 32'hBAD0BAD0);
        chk("t4_stray_resp", {mem_rd, CCU_ready}, 2'b10);
        mem_resp(32'hCAFEF00D);
        chk("t4_ready", CCU_ready, 1);
        chk("t4_data", data_out_CCU, 32'hCAFEF00D);
        chk("t4_state", cache_upd_state_core, 2'b11);
        tick;

        // write hit on E: no bus, ready two edges after accept; held req_valid ignored
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h3000; req_state = 2'b10;
        tick;
        req_write = 1'b0; req_addr = 32'h4444; req_state = 2'b00;
        chk("t5_busy", {ccu_busy, CCU_ready, bs_req}, 3'b100);
        tick;
        req_valid = 1'b0;
        chk("t5_ready", {CCU_ready, bs_req}, 2'b10);
        chk("t5_state", cache_upd_state_core, 2'b11);
        chk("t5_data", data_out_CCU, 0);
        tick;
        chk("t5_done", {ccu_busy, CCU_ready}, 0);
        tick;
        chk("t5_second_ignored", {ccu_busy, bs_req}, 0);

        // read on M: state unchanged
        request(1'b0, 32'h5000, 2'b11);
        tick;
        chk("t5b_state", {CCU_ready, cache_upd_state_core}, 3'b111);
        tick;

        // reset while in MEM_RD
        request(1'b0, 32'h00004000, 2'b00);
        tick;
        snoop_resp(1'b0, 1'b0, 32'h0);
        chk("t6_memrd", mem_rd, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("t6_cleared", {ccu_busy, CCU_ready, bs_req, mem_rd, mem_wr}, 0);
        chk("t6_addr", mem_addr, 0);
        mem_resp(32'h11111111);
        tick;
        chk("t6_no_ready", {CCU_ready, ccu_busy}, 0);
        request(1'b0, 32'h6000, 2'b10);
        tick;
        chk("t6_after_ready", CCU_ready, 1);
        chk("t6_after_state", cache_upd_state_core, 2'b10);
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ccu_snoop_ctrl.md
Name: ccu_snoop_ctrl

Overview:
- Cache coherence unit (CCU) directly downstream of the core-0 cache controller.
- Accepts one coherence request per miss or upgrade and broadcasts a snoop to the peer cache.
- Sources the line word from the peer or from memory, writes dirty peer data back, and returns the data plus the new MESI state to the requester.
- MESI encoding: I=2'b00, S=2'b01, E=2'b10, M=2'b11.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data word width
- SNOOP_TIMEOUT, 16, cycles to wait for bs_resp before treating the snoop as a miss (range 2..255)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  coherence request from the cache controller
- req_write  in  1  0=read, 1=write
- req_addr  in  ADDR_W  request address
- req_state  in  2  requester's current MESI state for the line
- ccu_busy  out  1  high from acceptance until the CCU_ready cycle inclusive
- CCU_ready  out  1  one-cycle completion pulse
- data_out_CCU  out  DATA_W  returned word, valid while CCU_ready=1
- cache_upd_state_core  out  2  new requester state, valid while CCU_ready=1
- bs_req  out  1  snoop request to the peer cache
- snoop_address  out  ADDR_W  snoop address
- snoop_type  out  2  01=BusRd, 10=BusRdX, 11=BusUpgr, 00=none
- bs_resp  in  1  peer snoop response strobe
- snoop_hit  in  1  peer held the line; sampled with bs_resp
- snoop_dirty  in  1  peer held the line in M; sampled with bs_resp
- snoop_data  in  DATA_W  peer data; sampled with bs_resp
- mem_rd  out  1  memory read request
- mem_wr  out  1  memory write-back request
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  write-back data
- mem_rdata  in  DATA_W  read data; sampled with mem_ack
- mem_ack  in  1  memory completion strobe

Behaviour:
- Reset: all outputs 0; FSM in IDLE; snoop and memory registers cleared.
- Reset asserted mid-operation drops the in-flight request. No CCU_ready pulse is produced for it.
- All outputs are registered.
- FSM states: IDLE, SNOOP, WB_MEM, MEM_RD, DONE.
- IDLE: req_valid=1 latches req_write, req_addr and req_state. ccu_busy rises on the next cycle.
- req_valid while ccu_busy=1 is ignored; the requester holds it until it sees CCU_ready.
- No-bus cases (next state DONE, no bus or memory activity, data_out_CCU=0):
  - read with req_state S/E/M: state unchanged.
  - write with req_state E or M: new state M.
- Bus cases (next state SNOOP):
  - read, req_state I: BusRd.
  - write, req_state I: BusRdX.
  - write, req_state S: BusUpgr.
- SNOOP: bs_req=1, snoop_address=latched address, snoop_type set. All three are held stable until bs_resp=1 is sampled. bs_req drops on the cycle after that sample.
- Snoop timeout: a cycle counter starts at SNOOP_TIMEOUT. Reaching 0 without bs_resp is treated as hit=0, dirty=0. If bs_resp and expiry occur in the same cycle, bs_resp wins.
- Snoop resolution:
  - BusUpgr: any response goes to DONE with state M and data 0.
  - BusRd, hit and dirty: data=snoop_data, state S; go to WB_MEM (mem_wr=1, mem_addr=addr, mem_wdata=snoop_data).
  - BusRd, hit and clean: data=snoop_data, state S; go to DONE.
  - BusRd, no hit: go to MEM_RD, final state E.
  - BusRdX, hit (clean or dirty): data=snoop_data, state M; go to DONE. Ownership transfers, so there is no write-back.
  - BusRdX, no hit: go to MEM_RD, final state M.
- WB_MEM and MEM_RD: mem_wr or mem_rd is held high, with stable address and data, until mem_ack is sampled. In MEM_RD the data is taken from mem_rdata. Then go to DONE. mem_rd and mem_wr are never high together.
- DONE: CCU_ready=1 for exactly one cycle with data_out_CCU and cache_upd_state_core valid. Return to IDLE.
- A new request is accepted no earlier than the cycle after DONE.
- Latency:
  - No-bus case: CCU_ready 2 cycles after the accepting edge.
  - Snoop-only case: bs_resp sample edge + 1 cycle.
- bs_resp or mem_ack arriving while not waiting for it is ignored.

Test Plan:
- Read miss, peer miss:
  - Stimulus: req_state=I, addr=0xAABBCCDD; bs_resp after 3 cycles with hit=0; mem_ack with mem_rdata=0xDEADBEEF.
  - Required: bs_req with snoop_type=01; then mem_rd at 0xAABBCCDD; CCU_ready with data 0xDEADBEEF, state E.
- Read miss, peer dirty:
  - Stimulus: hit=1, dirty=1, snoop_data=0x12345678.
  - Required: mem_wr with mem_wdata=0x12345678 at 0xAABBCCDD; after mem_ack, CCU_ready with data 0x12345678, state S.
- Write on S:
  - Stimulus: req_write=1, req_state=S.
  - Required: snoop_type=11; no mem_rd/mem_wr; CCU_ready with state M, data 0.
- Write miss, snoop timeout:
  - Stimulus: bs_resp never asserted.
  - Required: after SNOOP_TIMEOUT=16 cycles bs_req drops; mem_rd issued; CCU_ready with state M.
- Write hit on E:
  - Required: CCU_ready 2 cycles after acceptance, state M, bs_req never asserted.
  - Also: a second req_valid raised while busy is ignored.
- Reset in MEM_RD:
  - Stimulus: rst pulsed while mem_rd=1.
  - Required: next cycle all outputs are 0 and FSM is IDLE; no CCU_ready; a following request completes normally.
